pbit_frame_unpacker: RTL and testbench

//  Parametrised successor to the fixed-size pbit unpacker on the FMC receive path.
//  - Accepts a beat stream of DATA_WIDTH-bit words with valid/ready/last handshake.
//  - Assembles one frame of TOTAL_NUM_PBITS pbits in a shadow buffer.
//  - Commits a complete frame atomically to the pbits output, so the p-computer core never sees a torn frame.
//  - Detects and drops malformed (short/long) frames.

---
 rtl/pbit_unpack_pkg.sv | 14 +
 rtl/pbit_shadow_buffer.sv | 33 +++
 rtl/pbit_frame_unpacker.sv | 136 +++++++++++++
 tb/tb_pbit_frame_unpacker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pbit_unpack_pkg.sv
// Shared types and sizing helpers for the pbit frame unpacker.
package pbit_unpack_pkg;

  typedef enum logic {RECV = 1'b0, DROP = 1'b1} state_t;

  function automatic int beats_per_frame(input int total, input int width);
    return (total + width - 1) / width;
  endfunction

  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/pbit_shadow_buffer.sv
// Per-beat shadow storage. The frame output shows the stored beats, with the
// beat being written this cycle forwarded in, so a commit can include it.
module pbit_shadow_buffer
  import pbit_unpack_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int TOTAL_NUM_PBITS = 1024,
  parameter int BEATS           = beats_per_frame(TOTAL_NUM_PBITS, DATA_WIDTH),
  parameter int IDX_W           = idx_width(BEATS)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [TOTAL_NUM_PBITS-1:0] frame
);

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    // The last slot only keeps the bits that land inside the frame.
    localparam int BW = (b == BEATS - 1) ? TOTAL_NUM_PBITS - b * DATA_WIDTH : DATA_WIDTH;
    logic [BW-1:0] mem;
    logic          hit;

    assign hit = wr_en && (wr_idx == IDX_W'(b));

    always_ff @(posedge clk) begin
      if (hit) mem <= wr_data[BW-1:0];
    end

    assign frame[b*DATA_WIDTH +: BW] = hit ? wr_data[BW-1:0] : mem;
  end

endmodule

// File: rtl/pbit_frame_unpacker.sv
// Beat-stream to pbit-frame unpacker with atomic commit and malformed-frame drop.
// Optional saturating error counter: define PBIT_UNPACK_ERR_CNT_EN.
module pbit_frame_unpacker
  import pbit_unpack_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int TOTAL_NUM_PBITS = 1024,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [TOTAL_NUM_PBITS-1:0] pbits,
  output logic                       pbits_valid,
  output logic                       frame_err,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);

  localparam int BEATS = beats_per_frame(TOTAL_NUM_PBITS, DATA_WIDTH);
  localparam int IDX_W = idx_width(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic                       rdy;
  logic                       s1_vld, s1_last;
  logic [DATA_WIDTH-1:0]      s1_data;
  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       wr_en, commit, err;
  logic [TOTAL_NUM_PBITS-1:0] frame;

  assign s_axis_tready = rdy;

  // Stage 1: register the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy     <= 1'b0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
    end else begin
      rdy     <= 1'b1;
      s1_vld  <= s_axis_tvalid & rdy;
      s1_last <= s_axis_tlast;
      if (s_axis_tvalid && rdy) s1_data <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    if (s1_vld) begin
      unique case (state_q)
        RECV: begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s1_last) begin
              commit = 1'b1;
            end else begin
              err     = 1'b1;
              state_d = DROP;
            end
          end else if (s1_last) begin
            err   = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DROP: begin
          if (s1_last) begin
            state_d = RECV;
            idx_d   = '0;
          end
        end
        default: state_d = RECV;
      endcase
    end
  end

  // Stage 2: shadow write; a commit copies the shadow including this beat.
  pbit_shadow_buffer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .TOTAL_NUM_PBITS (TOTAL_NUM_PBITS),
    .BEATS           (BEATS),
    .IDX_W           (IDX_W)
  ) u_shadow (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (s1_data),
    .frame   (frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbits       <= '0;
      pbits_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pbits_valid <= commit;
      frame_err   <= err;
      if (commit) pbits <= frame;
    end
  end

`ifdef PBIT_UNPACK_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_cnt_q <= '0;
    else if (err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_pbit_frame_unpacker.sv
// Randomized scoreboard bench: a driver pushes expected commits/errors per frame,
// a negedge monitor pops and checks them along with pbits, tready and err_count.
module tb_pbit_frame_unpacker;

  localparam int DW    = 256;
  localparam int TP    = 600;
  localparam int EW    = 16;
  localparam int BEATS = (TP + DW - 1) / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic [TP-1:0] pbits;
  logic          pv, ferr;
  logic [EW-1:0] ecnt;

  pbit_frame_unpacker #(
    .DATA_WIDTH      (DW),
    .TOTAL_NUM_PBITS (TP),
    .ERR_CNT_WIDTH   (EW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .pbits         (pbits),
    .pbits_valid   (pv),
    .frame_err     (ferr),
    .err_count     (ecnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [TP-1:0] val;
    int            at;
  } ev_t;

  ev_t           sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [TP-1:0] exp_pbits = '0;
  int            exp_errs  = 0;

  task automatic chk(input bit ok, input string name, input logic [TP-1:0] act, input logic [TP-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] exp_cnt();
`ifdef PBIT_UNPACK_ERR_CNT_EN
    return (exp_errs >= (1 << EW) - 1) ? {EW{1'b1}} : EW'(exp_errs);
`else
    return '0;
`endif
  endfunction

  // Monitor
  always @(negedge clk) begin
    ev_t ev;
    if (!rst_n) begin
      exp_pbits = '0;
      exp_errs  = 0;
      chk(pbits == '0, "reset_pbits", pbits, '0);
      chk(!pv && !ferr && !tready && ecnt == '0, "reset_ctl",
          TP'({pv, ferr, tready, ecnt}), '0);
    end else begin
      if (pv || ferr) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_event", TP'({pv, ferr}), '0);
        end else begin
          ev = sb.pop_front();
          chk(ferr == ev.is_err && pv == !ev.is_err, "event_kind",
              TP'({pv, ferr}), TP'({!ev.is_err, ev.is_err}));
          chk(cyc == ev.at, "event_latency", TP'(cyc), TP'(ev.at));
          if (ev.is_err) exp_errs++;
          else           exp_pbits = ev.val;
        end
      end
      chk(pbits == exp_pbits, "pbits", pbits, exp_pbits);
      chk(tready == 1'b1, "tready", TP'(tready), TP'(1));
      chk(ecnt == exp_cnt(), "err_count", TP'(ecnt), TP'(exp_cnt()));
    end
  end

  // A frame of len beats is good only when len == BEATS; any other length
  // yields exactly one error, decided at the last beat or at beat BEATS.
  task automatic send_frame(input int len, input int idle_pct, input bit ones_last);
    logic [BEATS*DW-1:0] flat;
    logic [DW-1:0]       d;
    ev_t                 ev;
    int                  decide;
    flat   = '0;
    decide = ((len < BEATS) ? len : BEATS) - 1;
    for (int k = 0; k < len; k++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      if (ones_last && k == BEATS - 1) d = '1;
      while ($urandom_range(99) < idle_pct) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(posedge clk); #1;
      end
      tdata  = d;
      tvalid = 1'b1;
      tlast  = (k == len - 1);
      if (k < BEATS) flat[k*DW +: DW] = d;
      if (k == decide) begin
        ev.is_err = (len != BEATS);
        ev.val    = flat[TP-1:0];
        ev.at     = cyc + 2;
        sb.push_back(ev);
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    idle(3);
    release_reset();

    // Good frames back to back, continuous valid
    for (int i = 0; i < 3; i++) send_frame(BEATS, 0, 1'b0);
    idle(3);
    // Short frames followed by a good frame
    for (int l = 1; l < BEATS; l++) send_frame(l, 0, 1'b0);
    send_frame(BEATS, 0, 1'b0);
    // Long frames, then good frames
    send_frame(BEATS + 1, 0, 1'b0);
    send_frame(BEATS + 3, 0, 1'b0);
    send_frame(BEATS, 0, 1'b0);
    // Padding bits in the last beat all ones
    send_frame(BEATS, 10, 1'b1);
    idle(3);

    // Reset mid-frame: partial frame is lost
    tdata  = '1;
    tvalid = 1'b1;
    tlast  = 1'b0;
    idle(2);
    tvalid = 1'b0;
    rst_n  = 1'b0;
    idle(2);
    release_reset();
    send_frame(BEATS, 0, 1'b0);
    idle(3);

    // Randomized mix with idle gaps
    for (int i = 0; i < 60; i++) begin
      len = ($urandom_range(2) != 0) ? BEATS : $urandom_range(BEATS + 2, 1);
      send_frame(len, 20, $urandom_range(3) == 0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(2);
    chk(sb.size() == 0, "drain", TP'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
